// File: rtl/shift_arb.sv
// shift_arb: two-requester round-robin arbiter feeding an external shift_reg
// of DEPTH cycles latency. A {valid, id} tag pipeline travels alongside the
// data so the far side knows which bytes are real and where they came from.
// A flush request stops acceptance, waits for the tag pipeline to empty and
// then pulses flush_done for one cycle.
//
// Optional feature macro: SHIFT_ARB_STATS_EN adds saturating 16-bit
// accepted-byte counters cnt0/cnt1.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_RUN   | normal arbitration, requesters may transfer
// ST_DRAIN | acceptance stopped, waiting for tag pipeline to empty
// ST_DONE  | drain complete, flush_done high for this single cycle

module shift_arb #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  input  logic             flush,
  output logic             flush_done,
  output logic             busy,
  output logic [WIDTH-1:0] sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out,
  output logic             out_valid,
  output logic             out_id,
`ifdef SHIFT_ARB_STATS_EN
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1,
`endif
  output logic [WIDTH-1:0] out_data
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           state;
  logic             last;
  logic             run;
  logic             gnt_id;
  logic             xfer;
  logic [DEPTH-1:0] tag_v;
  logic [DEPTH-1:0] tag_id;

  // Readies are held low while reset is asserted, even though the FSM
  // already sits in RUN, so nothing is accepted during reset.
  assign run = rst_n && (state == ST_RUN);

  // req1 wins when it is the only requester, or on contention when req0
  // had the previous grant.
  assign gnt_id     = req1_valid && (!req0_valid || !last);
  assign req0_ready = run && !gnt_id;
  assign req1_ready = run && gnt_id;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign sr_data_in = xfer ? (gnt_id ? req1_data : req0_data) : '0;

  assign out_valid = tag_v[DEPTH-1];
  assign out_id    = tag_id[DEPTH-1];
  assign out_data  = sr_data_out;
  assign busy      = (|tag_v) || (state != ST_RUN);

  // Flush sequencing with registered completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_RUN;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      case (state)
        ST_RUN: begin
          if (flush) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (tag_v == '0) begin
            state      <= ST_DONE;
            flush_done <= 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_RUN;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  // Round-robin history: remembers which requester got the last transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (xfer) begin
      last <= gnt_id;
    end
  end

  // Tag pipeline shifts every cycle so it stays aligned with shift_reg.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v[0]  <= xfer;
      tag_id[0] <= xfer && gnt_id;
      for (int i = 1; i < DEPTH; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

`ifdef SHIFT_ARB_STATS_EN
  // Per-requester accepted-byte counters, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (xfer && !gnt_id && (cnt0 != 16'hFFFF)) cnt0 <= cnt0 + 16'd1;
      if (xfer && gnt_id && (cnt1 != 16'hFFFF))  cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: doc/shift_arb.md
# shift_arb

Two-requester round-robin arbiter and sequencer for the `shift_reg` datapath. It multiplexes bytes from two valid/ready sources onto the shift register input and tracks each byte through the DEPTH-cycle shift latency with a tag pipeline. At the far side it emits a valid flag and source ID alongside the shift register output. A flush state machine drains in-flight data before signalling completion.

## Interface
- `DEPTH`, 4, latency of the attached `shift_reg` in cycles (data on `sr_data_in` in cycle t is on `sr_data_out` in cycle t+DEPTH); legal range ≥1
- `WIDTH`, 8, data width
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req0_valid` / `req1_valid`  in  1  requester has a byte
- `req0_data` / `req1_data`  in  WIDTH  requester byte
- `req0_ready` / `req1_ready`  out  1  byte accepted this cycle if valid is also high
- `flush`  in  1  level request to stop accepting and drain
- `flush_done`  out  1  single-cycle pulse when drain is complete
- `busy`  out  1  any byte in flight, or FSM not in RUN
- `sr_data_in`  out  WIDTH  to `shift_reg.data_in`
- `sr_data_out`  in  WIDTH  from `shift_reg.data_out`
- `out_valid`  out  1  `out_data` holds an accepted byte
- `out_id`  out  1  source of `out_data` (0/1)
- `out_data`  out  WIDTH  equals `sr_data_out`
- `cnt0` / `cnt1`  out  16  accepted-byte counters (present only with `SHIFT_ARB_STATS_EN`)

## Operation
- FSM states: RUN (reset state), DRAIN, DONE.
  - RUN → DRAIN when `flush`=1 at a clock edge.
  - DRAIN → DONE when the tag pipeline is all-invalid.
  - DONE → RUN unconditionally after one cycle.
  - `flush` is ignored in DRAIN and DONE.
- Grant is combinational and only valid in RUN.
  - If one valid is high, that requester is granted.
  - If both are high, the requester other than `last` is granted.
  - `last` is a 1-bit register, reset to 1, so req0 wins the first contention.
  - `last` updates to the granted ID on each transfer.
- `reqN_ready` = RUN && grant==N. Ready may depend on valid. Both readies are 0 in DRAIN and DONE.
- Transfer = valid && ready, at most one per cycle.
- `sr_data_in` = granted data on a transfer cycle, otherwise all-zero.
- Tag pipeline: DEPTH entries of {valid, id}, shifting every cycle unconditionally. Entry 0 is loaded with {transfer, granted id}.
- `out_valid`/`out_id` come from the last pipeline entry. `out_data` = `sr_data_out` combinationally.
- No downstream backpressure. Output bytes are presented for exactly one cycle.
- Flush in the same cycle as a transfer: the transfer completes and that byte is drained before `flush_done`.

## Timing
- Reset values: `req*_ready`=0 while `rst_n`=0; `flush_done`=0; `busy`=0; `out_valid`=0; `out_id`=0; `sr_data_in`=0; all tag entries invalid; `last`=1; FSM=RUN; counters=0.
- Latency: a transfer in cycle t gives `out_valid`=1 in cycle t+DEPTH. Back-to-back transfers give back-to-back outputs.
- Throughput: one byte per cycle.
- `flush_done` is high for exactly the one DONE cycle. Earliest `flush_done` after `flush` is sampled with k bytes in flight is ≤DEPTH+1 cycles.
- Reset asserted mid-operation: tag pipeline clears immediately (async). `out_valid` drops the same cycle. In-flight bytes are discarded. FSM returns to RUN.
- DEPTH=1: tag pipeline is a single register; all rules above hold.

## Configuration
- `SHIFT_ARB_STATS_EN` defined: ports `cnt0`/`cnt1` exist.
  - Each counter increments on its requester's transfer.
  - Counters saturate at 16'hFFFF.
  - Cleared only by reset.
- Not defined: ports and counter logic are absent. All other behaviour is identical.

## Test plan
- req0 only, DEPTH=4, bytes 1..8 with valid continuously high: readies high every cycle; `out_valid` high cycles t+4..t+11 with `out_id`=0 and data 1..8 in order.
- Both valid continuously, req0 streaming 0x10.., req1 streaming 0xA0..: grants alternate 0,1,0,1 starting with req0; output is 0x10,0xA0,0x11,0xA1.
- Three bytes in flight, `flush` pulsed one cycle alongside a transfer: readies drop the next cycle; all four bytes emerge; `flush_done` pulses once; `busy` falls; readies return the cycle after DONE.
- `rst_n` low for 2 cycles with 3 bytes in flight: `out_valid` drops immediately and stays 0; after release, req1 alone is accepted on the first valid cycle.
- DEPTH=1 with alternating valid/idle cycles: each byte appears exactly one cycle later; `sr_data_in`=0 on idle cycles.
- With `SHIFT_ARB_STATS_EN`, `cnt0` forced near 16'hFFFE and three req0 transfers: `cnt0` reads 16'hFFFF and holds; `cnt1` unchanged.
